// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: the in_op select codes
// and the MIPS opcode/funct fields they map to.
package instr_encoder_pkg;

   typedef enum logic [3:0] {
      SEL_NOP = 4'd0,
      SEL_ADD = 4'd1,
      SEL_SUB = 4'd2,
      SEL_ORI = 4'd3,
      SEL_LUI = 4'd4,
      SEL_BEQ = 4'd5,
      SEL_JAL = 4'd6,
      SEL_JR  = 4'd7,
      SEL_LW  = 4'd8,
      SEL_SW  = 4'd9
   } op_sel_e;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_ADD    = 6'h20;
   localparam logic [5:0] FN_SUB    = 6'h22;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded words; head is presented as soon as it is
// written, and reads as zero while empty.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_MAX);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage array; contents are don't-care until counted as occupied.
   always_ff @(posedge clk) begin
      if (w_do_push && !reset) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes mnemonic requests into MIPS words, queues them, and tags the head
// word with its address; illegal selects enqueue a zero word and latch err.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int          DEPTH   = 4,
   parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_op,
   input  logic [4:0]               in_rs,
   input  logic [4:0]               in_rt,
   input  logic [4:0]               in_rd,
   input  logic [15:0]              in_imm,
   input  logic [25:0]              in_index,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   logic [31:0] w_enc;
   logic        w_illegal;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic [31:0] r_pc;
   logic        r_err;

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign out_pc    = r_pc;
   assign err       = r_err;

   // Field selection per op; anything an op does not use is zero.
   always_comb begin
      w_enc     = 32'h0000_0000;
      w_illegal = 1'b0;
      case (in_op)
         SEL_NOP: w_enc = 32'h0000_0000;
         SEL_ADD: w_enc = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_ADD};
         SEL_SUB: w_enc = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_SUB};
         SEL_ORI: w_enc = {OPC_ORI, in_rs, in_rt, in_imm};
         SEL_LUI: w_enc = {OPC_LUI, 5'h00, in_rt, in_imm};
         SEL_BEQ: w_enc = {OPC_BEQ, in_rs, in_rt, in_imm};
         SEL_JAL: w_enc = {OPC_JAL, in_index};
         SEL_JR:  w_enc = {OPC_RTYPE, in_rs, 15'h0000, FN_JR};
         SEL_LW:  w_enc = {OPC_LW, in_rs, in_rt, in_imm};
         SEL_SW:  w_enc = {OPC_SW, in_rs, in_rt, in_imm};
         default: begin
            w_enc     = 32'h0000_0000;
            w_illegal = 1'b1;
         end
      endcase
   end

   // Head address advances with every consumed word; err is sticky until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc  <= PC_BASE;
         r_err <= 1'b0;
      end else begin
         if (w_pop) begin
            r_pc <= r_pc + 32'd4;
         end
         if (w_push && w_illegal) begin
            r_err <= 1'b1;
         end
      end
   end

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (w_enc),
      .i_pop   (w_pop),
      .o_dout  (out_instr),
      .o_count (count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against a queue-based reference model,
// with directed sequences pinned by hand-computed words.
module tb_instr_encoder;

   localparam int          DEPTH   = 4;
   localparam logic [31:0] PC_BASE = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_index;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  count;
   logic        err;

   instr_encoder #(.DEPTH(DEPTH), .PC_BASE(PC_BASE)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_index(in_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .count(count), .err(err)
   );

   always #5 clk = ~clk;

   logic [31:0] q[$];
   logic [31:0] m_pc;
   logic        m_err;
   int          n_vec  = 0;
   int          n_fail = 0;

   // Reference encoding built from opcode numbers and field positions.
   function automatic logic [31:0] m_enc(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] idx);
      logic [31:0] r_part, i_part;
      r_part = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
      i_part = (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      case (op)
         4'd1:    return r_part + 32'd32;
         4'd2:    return r_part + 32'd34;
         4'd3:    return (32'd13 << 26) | i_part;
         4'd4:    return (32'd15 << 26) | (32'(rt) << 16) | 32'(imm);
         4'd5:    return (32'd4 << 26) | i_part;
         4'd6:    return (32'd3 << 26) | 32'(idx);
         4'd7:    return (32'(rs) << 21) + 32'd8;
         4'd8:    return (32'd35 << 26) | i_part;
         4'd9:    return (32'd43 << 26) | i_part;
         default: return 32'd0;
      endcase
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all();
      cmp("count", 32'(count), 32'(q.size()));
      cmp("out_valid", 32'(out_valid), 32'(q.size() != 0));
      cmp("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      cmp("out_instr", out_instr, (q.size() != 0) ? q[0] : 32'd0);
      cmp("out_pc", out_pc, m_pc);
      cmp("err", 32'(err), 32'(m_err));
   endtask

   // One clock: decide acceptance from pre-edge state, update model, check.
   task automatic cyc();
      logic acc, con;
      acc = !reset && in_valid && (q.size() < DEPTH);
      con = !reset && (q.size() != 0) && out_ready;
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_pc  = PC_BASE;
         m_err = 1'b0;
      end else begin
         if (con) begin
            void'(q.pop_front());
            m_pc = m_pc + 32'd4;
         end
         if (acc) begin
            q.push_back(m_enc(in_op, in_rs, in_rt, in_rd, in_imm, in_index));
            if (in_op > 4'd9) m_err = 1'b1;
         end
      end
      #1;
      check_all();
   endtask

   task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] idx);
      in_valid = 1'b1;
      in_op    = op;
      in_rs    = rs;
      in_rt    = rt;
      in_rd    = rd;
      in_imm   = imm;
      in_index = idx;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0; in_index = 26'd0;
      m_pc = PC_BASE; m_err = 1'b0;
      cyc();
      do_reset();
      cmp("rst_count", 32'(count), 32'd0);
      cmp("rst_in_ready", 32'(in_ready), 32'd1);
      cmp("rst_out_pc", out_pc, 32'h0000_3000);
      cmp("rst_out_instr", out_instr, 32'h0000_0000);

      // ADD rs=1 rt=2 rd=3, visible one cycle after acceptance
      set_req(4'd1, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h3FF_FFFF);
      cyc();
      in_valid = 1'b0;
      cmp("add_lit", out_instr, 32'h0022_1820);
      cmp("add_pc", out_pc, 32'h0000_3000);
      do_reset();

      // ORI / LUI / SW stream, then drain
      set_req(4'd3, 5'd0, 5'd1, 5'd9, 16'h1234, 26'h155_5555); cyc();
      set_req(4'd4, 5'd7, 5'd2, 5'd9, 16'hFFFF, 26'h155_5555); cyc();
      set_req(4'd9, 5'd0, 5'd4, 5'd9, 16'h0008, 26'h155_5555); cyc();
      in_valid = 1'b0; out_ready = 1'b1;
      cmp("ori_lit", out_instr, 32'h3401_1234); cmp("ori_pc", out_pc, 32'h0000_3000); cyc();
      cmp("lui_lit", out_instr, 32'h3C02_FFFF); cmp("lui_pc", out_pc, 32'h0000_3004); cyc();
      cmp("sw_lit", out_instr, 32'hAC04_0008);  cmp("sw_pc", out_pc, 32'h0000_3008); cyc();
      out_ready = 1'b0;

      // JAL then JR
      set_req(4'd6, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h000_0C03); cyc();
      set_req(4'd7, 5'd31, 5'd6, 5'd7, 16'hFFFF, 26'h3FF_FFFF); cyc();
      in_valid = 1'b0;
      cmp("jal_lit", out_instr, 32'h0C00_0C03);
      out_ready = 1'b1; cyc();
      cmp("jr_lit", out_instr, 32'h03E0_0008);
      cyc();
      out_ready = 1'b0;

      // Fill to full, fifth request held until a consume frees a slot
      for (int k = 0; k < 5; k++) begin
         set_req(4'd1, 5'd0, 5'd0, 5'(k + 1), 16'd0, 26'd0);
         cyc();
         if (k == 3) begin
            cmp("full_in_ready", 32'(in_ready), 32'd0);
            cmp("full_count", 32'(count), 32'd4);
         end
      end
      out_ready = 1'b1; cyc();
      out_ready = 1'b0; cyc();
      in_valid = 1'b0;
      cmp("refill_count", 32'(count), 32'd4);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      out_ready = 1'b0;

      // Illegal op enqueues zero and latches err
      set_req(4'hF, 5'd3, 5'd3, 5'd3, 16'h1111, 26'h111_1111); cyc();
      cmp("illegal_word", out_instr, 32'h0000_0000);
      cmp("illegal_err", 32'(err), 32'd1);
      set_req(4'd2, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0); cyc();
      in_valid = 1'b0;
      cmp("err_sticky", 32'(err), 32'd1);

      // Reset mid-stream with three queued words
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_req(4'd8, 5'(k), 5'(k + 4), 5'd0, 16'(k), 26'd0);
         cyc();
      end
      cmp("pre_rst_count", 32'(count), 32'd3);
      set_req(4'd1, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0);
      do_reset();
      in_valid = 1'b0;
      cmp("mid_rst_count", 32'(count), 32'd0);
      cmp("mid_rst_valid", 32'(out_valid), 32'd0);
      cmp("mid_rst_pc", out_pc, 32'h0000_3000);
      cmp("mid_rst_err", 32'(err), 32'd0);

      // Randomized traffic with occasional reset
      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_op     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         in_rs     = 5'($urandom);
         in_rt     = 5'($urandom);
         in_rd     = 5'($urandom);
         in_imm    = 16'($urandom);
         in_index  = 26'($urandom);
         reset     = ($urandom_range(0, 299) == 0);
         cyc();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
